// File: rtl/memory_responder.sv
// rtl/memory_responder.sv - single-port word memory with self-zeroing init sweep and registered reads
//
// Purpose:
//   2^ADDR_W x DATA_W memory. After reset or clear_i the array is swept to
//   zero, one word per clock. During the sweep no requests are accepted.
//   After the sweep, one read or write is accepted every cycle. Read data
//   is registered and appears one cycle after the accepting edge.
//
// Ports:
//   clk        - clock; all state updates on its rising edge
//   rst_n      - asynchronous active-low reset
//   clear_i    - synchronous request to re-zero the whole array
//   req_i      - access request, accepted when ready_o is 1
//   we_i       - access type: 1 = write, 0 = read
//   addr_i     - access address
//   data_i     - write data
//   ready_o    - 1 when a request can be accepted this cycle
//   q_o        - registered read data; holds its value until the next read
//   q_valid_o  - one-cycle pulse marking new q_o data
module memory_responder #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ready_o,
  output logic [DATA_W-1:0] q_o,
  output logic              q_valid_o
);

  typedef enum logic {
    INIT = 1'b0,
    IDLE = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [DATA_W-1:0] q_q, q_d;
  logic              q_valid_q, q_valid_d;

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  assign ready_o   = (state_q == IDLE);
  assign q_o       = q_q;
  assign q_valid_o = q_valid_q;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    q_d       = q_q;
    q_valid_d = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = addr_i;
    mem_wdata = data_i;

    // clear_i takes priority over both the sweep and any request on the
    // same edge; the sweep then starts over at address 0 on the next edge.
    if (clear_i) begin
      state_d   = INIT;
      clr_cnt_d = '0;
    end else begin
      case (state_q)
        INIT: begin
          mem_we    = 1'b1;
          mem_waddr = clr_cnt_q;
          mem_wdata = '0;
          // Counter wraps to 0 naturally on the edge that writes the last word.
          clr_cnt_d = clr_cnt_q + ADDR_W'(1);
          if (clr_cnt_q == {ADDR_W{1'b1}}) begin
            state_d = IDLE;
          end
        end
        IDLE: begin
          if (req_i) begin
            if (we_i) begin
              mem_we = 1'b1;
            end else begin
              q_d       = mem_q[addr_i];
              q_valid_d = 1'b1;
            end
          end
        end
        default: begin
          state_d   = INIT;
          clr_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= INIT;
      clr_cnt_q <= '0;
      q_q       <= '0;
      q_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
    end
  end

  // Array has no reset; it is zeroed by the INIT sweep instead. Any write
  // issued while rst_n is low can only come from INIT and writes zero.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_memory_responder.sv
// tb/tb_memory_responder.sv - self-checking bench for memory_responder
module tb_memory_responder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       clear_i = 1'b0;
  logic       req_i = 1'b0;
  logic       we_i = 1'b0;
  logic [5:0] addr_i = '0;
  logic [7:0] data_i = '0;
  logic       ready_o;
  logic [7:0] q_o;
  logic       q_valid_o;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] model [64];
  logic [7:0] sb [$];

  memory_responder #(.DATA_W(8), .ADDR_W(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (clear_i),
    .req_i     (req_i),
    .we_i      (we_i),
    .addr_i    (addr_i),
    .data_i    (data_i),
    .ready_o   (ready_o),
    .q_o       (q_o),
    .q_valid_o (q_valid_o)
  );

  always #5 clk = ~clk;

  // Scoreboard consumer: every q_valid_o pulse must match the oldest expected read.
  always @(negedge clk) begin
    if (rst_n && q_valid_o) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL spurious_q_valid: q_valid_o=1 q_o=%02h, required no pulse", q_o);
      end else begin
        logic [7:0] exp;
        exp = sb.pop_front();
        if (q_o !== exp) begin
          miscompares++;
          $display("FAIL read_data: q_o=%02h required %02h", q_o, exp);
        end
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in;
    req_i   = 1'b0;
    we_i    = 1'b0;
    clear_i = 1'b0;
  endtask

  task automatic model_zero;
    for (int i = 0; i < 64; i++) model[i] = 8'h00;
  endtask

  // Issue one access for a single edge; expectation is recorded at drive time.
  task automatic access(input logic we, input logic [5:0] a, input logic [7:0] d);
    req_i  = 1'b1;
    we_i   = we;
    addr_i = a;
    data_i = d;
    if (we) model[a] = d;
    else    sb.push_back(model[a]);
    step();
  endtask

  task automatic sweep_check(input string name);
    for (int i = 1; i <= 64; i++) begin
      step();
      vectors++;
      if (ready_o !== (i == 64)) begin
        miscompares++;
        $display("FAIL %s_ready edge %0d: ready_o=%b required %b", name, i, ready_o, (i == 64));
      end
    end
  endtask

  task automatic check_valid(input string name, input logic exp);
    vectors++;
    if (q_valid_o !== exp) begin
      miscompares++;
      $display("FAIL %s: q_valid_o=%b required %b", name, q_valid_o, exp);
    end
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if (ready_o !== 1'b0 || q_valid_o !== 1'b0 || q_o !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_outputs: ready=%b q_valid=%b q=%02h required 0 0 00", ready_o, q_valid_o, q_o);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_zero();
  endtask

  task automatic test_powerup;
    sweep_check("powerup");
    access(1'b0, 6'h2A, 8'h00);
    idle_in();
    check_valid("powerup_pulse", 1'b1);
    vectors++;
    if (q_o !== 8'h00) begin
      miscompares++;
      $display("FAIL powerup_q: q_o=%02h required 00", q_o);
    end
    step();
    check_valid("powerup_pulse_end", 1'b0);
  endtask

  task automatic test_write_read;
    access(1'b1, 6'h3F, 8'hA5);
    check_valid("write_no_pulse", 1'b0);
    access(1'b0, 6'h3F, 8'h00);
    idle_in();
    check_valid("wr_rd_pulse", 1'b1);
    vectors++;
    if (q_o !== 8'hA5) begin
      miscompares++;
      $display("FAIL wr_rd_q: q_o=%02h required a5", q_o);
    end
    step();
    check_valid("wr_rd_pulse_end", 1'b0);
  endtask

  task automatic test_back_to_back;
    for (int a = 0; a < 64; a++) access(1'b1, 6'(a), 8'(a + 1));
    for (int a = 0; a < 64; a++) begin
      access(1'b0, 6'(a), 8'h00);
      check_valid("stream_valid", 1'b1);
    end
    idle_in();
    step();
    check_valid("stream_end", 1'b0);
  endtask

  task automatic test_clear_collision;
    access(1'b0, 6'h05, 8'h00);
    idle_in();
    step();
    clear_i = 1'b1;
    req_i   = 1'b1;
    we_i    = 1'b0;
    addr_i  = 6'h07;
    step();
    idle_in();
    check_valid("clear_collision_pulse", 1'b0);
    model_zero();
    sweep_check("clear");
    vectors++;
    if (q_o !== 8'h06) begin
      miscompares++;
      $display("FAIL clear_q_retained: q_o=%02h required 06", q_o);
    end
    for (int a = 0; a < 64; a++) access(1'b0, 6'(a), 8'h00);
    idle_in();
    step();
  endtask

  task automatic test_init_ignore;
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    req_i   = 1'b1;
    we_i    = 1'b1;
    addr_i  = 6'h10;
    data_i  = 8'hFF;
    for (int i = 0; i < 20; i++) begin
      step();
      check_valid("init_ignore_pulse", 1'b0);
    end
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    for (int i = 1; i <= 64; i++) begin
      step();
      if (i == 60) req_i = 1'b0;
      vectors++;
      if (ready_o !== (i == 64)) begin
        miscompares++;
        $display("FAIL restart_ready edge %0d: ready_o=%b required %b", i, ready_o, (i == 64));
      end
    end
    access(1'b0, 6'h10, 8'h00);
    idle_in();
    step();
  endtask

  task automatic test_reset_mid_read;
    access(1'b1, 6'h22, 8'h5C);
    access(1'b0, 6'h22, 8'h00);
    idle_in();
    vectors++;
    if (q_o !== 8'h5C || q_valid_o !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset_read: q=%02h valid=%b required 5c 1", q_o, q_valid_o);
    end
    rst_n = 1'b0;
    #1;
    sb.delete();
    vectors++;
    if (q_o !== 8'h00 || q_valid_o !== 1'b0 || ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_read_reset: q=%02h valid=%b ready=%b required 00 0 0", q_o, q_valid_o, ready_o);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_zero();
    sweep_check("rereset");
    access(1'b0, 6'h22, 8'h00);
    idle_in();
    step();
  endtask

  initial begin
    model_zero();
    test_reset();
    test_powerup();
    test_write_read();
    test_back_to_back();
    test_clear_collision();
    test_init_ignore();
    test_reset_mid_read();
    repeat (2) step();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL missing_reads: %0d expected reads never returned, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
